avmm_lvds_bridge_req_arb: RTL

- Packet-level arbiter that shares one bridge request link (the stream that feeds the request FIFO) among N_REQ local requesters.
- Grants round-robin and holds the grant for a whole packet (header + payload words) until the last word.
- Records grant order in an internal order FIFO and uses it to route in-order response packets back to the originating requester.

---
 rtl/avmm_lvds_bridge_req_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/avmm_lvds_bridge_req_arb.sv
// avmm_lvds_bridge_req_arb
// Packet-level arbiter sharing one bridge request link among N_REQ requesters.
// Grants round-robin, holds the grant for a whole packet, and remembers grant
// order in a small order FIFO so in-order responses can be routed back.
// Optional build macro: AVMM_LVDS_BRIDGE_ARB_PRIO0_EN gives requester 0 strict
// priority at every arbitration decision (round-robin among the others).
module avmm_lvds_bridge_req_arb #(
    parameter int N_REQ       = 4,
    parameter int OUTSTANDING = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ*32-1:0] s_data_i,
    input  logic [N_REQ-1:0]    s_valid_i,
    input  logic [N_REQ-1:0]    s_last_i,
    output logic [N_REQ-1:0]    s_ready_o,
    output logic [31:0]         tx_data_o,
    output logic                tx_valid_o,
    output logic                tx_last_o,
    input  logic                tx_ready_i,
    input  logic [31:0]         rx_data_i,
    input  logic                rx_valid_i,
    input  logic                rx_last_i,
    output logic [31:0]         r_data_o,
    output logic [N_REQ-1:0]    r_valid_o,
    output logic                r_last_o,
    output logic                busy_o,
    output logic                err_unexp_o
);
    localparam int GW = $clog2(N_REQ);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t        r_state;
    logic [GW-1:0] r_g;
    logic [GW-1:0] r_rr;
    logic [GW-1:0] r_fifo [OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic [N_REQ-1:0] w_rot;
    logic [GW:0]      w_off;
    logic [GW:0]      w_sum;
    logic [GW-1:0]    w_win;
    logic [GW-1:0]    w_head;
    logic [GW-1:0]    w_g_next;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_beat_last;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CW'(OUTSTANDING));
    assign w_head   = r_fifo[r_rptr];
    assign w_g_next = (r_g == GW'(N_REQ - 1)) ? '0 : r_g + 1'b1;

    // A full FIFO that is popping this cycle has room for the new entry at the
    // same edge, so the grant is not delayed a further cycle.
    assign w_pop       = rx_valid_i & rx_last_i & ~w_empty;
    assign w_push      = (r_state == IDLE) & (|s_valid_i) & (~w_full | w_pop);
    assign w_beat_last = (r_state == XFER) & tx_valid_o & tx_ready_i & tx_last_o;

    // Winner search: rotate valids so bit 0 is the rr pointer, take the lowest
    // set bit, then map the offset back to an absolute requester index.
    always_comb begin
        w_rot = N_REQ'({s_valid_i, s_valid_i} >> r_rr);
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = (GW+1)'(i);
        end
        w_sum = {1'b0, r_rr} + w_off;
        if (w_sum >= (GW+1)'(N_REQ)) w_sum = w_sum - (GW+1)'(N_REQ);
        w_win = w_sum[GW-1:0];
`ifdef AVMM_LVDS_BRIDGE_ARB_PRIO0_EN
        if (s_valid_i[0]) w_win = '0;
`endif
    end

    // Link side: the granted requester is muxed straight through during XFER.
    always_comb begin
        tx_data_o  = '0;
        tx_valid_o = 1'b0;
        tx_last_o  = 1'b0;
        s_ready_o  = '0;
        if (r_state == XFER) begin
            tx_data_o      = s_data_i[r_g*32 +: 32];
            tx_valid_o     = s_valid_i[r_g];
            tx_last_o      = s_last_i[r_g];
            s_ready_o[r_g] = tx_ready_i;
        end
    end

    // Response side: data broadcast, valid steered to the oldest grant.
    always_comb begin
        r_data_o  = rx_data_i;
        r_last_o  = rx_last_i;
        r_valid_o = '0;
        if (!w_empty) r_valid_o[w_head] = rx_valid_i;
    end

    assign busy_o      = (r_state != IDLE) | ~w_empty;
    assign err_unexp_o = r_err;

    // Request FSM: pick a winner in IDLE, hold it until its last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_g     <= w_win;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_beat_last) begin
                        r_state <= IDLE;
`ifdef AVMM_LVDS_BRIDGE_ARB_PRIO0_EN
                        if (r_g != '0) r_rr <= w_g_next;
`else
                        r_rr <= w_g_next;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Order FIFO pointers and occupancy; pointers wrap at OUTSTANDING.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Order FIFO storage; the head is read combinationally before any
    // same-edge overwrite when full.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr] <= w_win;
    end

    // Flag a response word that has no outstanding packet to belong to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_err <= 1'b0;
        else       r_err <= rx_valid_i & w_empty;
    end

endmodule
